// File: rtl/bus_pkg.sv
// Shared datapath bus definitions: default geometry, source index map and helpers
// used by the bus arbiter/multiplexer and its consumers.
package bus_pkg;

  localparam int BUS_WIDTH = 32;
  localparam int BUS_NSRC  = 24;
  localparam int BUS_SELW  = $clog2(BUS_NSRC);

  // Priority follows index order: R0 wins over everything, C loses to everything.
  typedef enum logic [BUS_SELW-1:0] {
    SRC_R0     = 5'd0,
    SRC_R1     = 5'd1,
    SRC_R2     = 5'd2,
    SRC_R3     = 5'd3,
    SRC_R4     = 5'd4,
    SRC_R5     = 5'd5,
    SRC_R6     = 5'd6,
    SRC_R7     = 5'd7,
    SRC_R8     = 5'd8,
    SRC_R9     = 5'd9,
    SRC_R10    = 5'd10,
    SRC_R11    = 5'd11,
    SRC_R12    = 5'd12,
    SRC_R13    = 5'd13,
    SRC_R14    = 5'd14,
    SRC_R15    = 5'd15,
    SRC_HI     = 5'd16,
    SRC_LO     = 5'd17,
    SRC_ZHI    = 5'd18,
    SRC_ZLO    = 5'd19,
    SRC_PC     = 5'd20,
    SRC_MDR    = 5'd21,
    SRC_INPORT = 5'd22,
    SRC_C      = 5'd23
  } bus_src_t;

  // One-hot drive-enable strobe for a named source.
  function automatic logic [BUS_NSRC-1:0] src_bit(input bus_src_t s);
    logic [BUS_NSRC-1:0] v;
    v    = '0;
    v[s] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/bus_arb_mux_if.sv
// Bus-side signal bundle of the arbiter/multiplexer: source words and strobes in,
// registered bus value and conflict status out.
interface bus_arb_mux_if
  import bus_pkg::*;
#(
  parameter int WIDTH = BUS_WIDTH,
  parameter int NSRC  = BUS_NSRC,
  parameter int CNT_W = 8
);
  localparam int SELW = $clog2(NSRC);

  // Strobe semantics: src_out[i] is a request sampled only at the rising edge; there
  // is no ready/back-pressure. bus_valid=1 means bus_out/bus_src carry the word that
  // won arbitration at the previous edge; bus_valid=0 means nobody drove it then.
  logic [NSRC*WIDTH-1:0] src_data;
  logic [NSRC-1:0]       src_out;
  logic                  conflict_clr;
  logic [WIDTH-1:0]      bus_out;
  logic                  bus_valid;
  logic [SELW-1:0]       bus_src;
  logic                  conflict;
  logic                  conflict_sticky;
  logic [CNT_W-1:0]      conflict_cnt;

  modport master (
    output src_data, src_out, conflict_clr,
    input  bus_out, bus_valid, bus_src, conflict, conflict_sticky, conflict_cnt
  );

  modport slave (
    input  src_data, src_out, conflict_clr,
    output bus_out, bus_valid, bus_src, conflict, conflict_sticky, conflict_cnt
  );

endinterface

// File: rtl/bus_prio_enc.sv
// Combinational priority encoder: lowest set request bit wins; also reports
// whether any request is present and whether more than one is.
module bus_prio_enc
  import bus_pkg::*;
#(
  parameter int N    = BUS_NSRC,
  parameter int SELW = $clog2(N)
) (
  input  logic [N-1:0]    req,
  output logic [SELW-1:0] index,
  output logic            any,
  output logic            multi
);

  // Scan from the top down so the lowest set index is the last assignment.
  always_comb begin
    index = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) index = SELW'(i);
    end
  end

  assign any = |req;

  // Clearing the lowest set bit leaves something only if two or more were set.
  assign multi = |(req & (req - N'(1)));

endmodule

// File: rtl/bus_arb_mux.sv
// Registered datapath bus multiplexer: priority-selects one source word per cycle,
// flags and counts multi-driver cycles, and holds or zeroes the bus when idle.
module bus_arb_mux
  import bus_pkg::*;
#(
  parameter int WIDTH     = BUS_WIDTH,
  parameter int NSRC      = BUS_NSRC,
  parameter int SELW      = $clog2(NSRC),
  parameter int HOLD_IDLE = 1,
  parameter int CNT_W     = 8
) (
  input logic          clk,
  input logic          clr,
  bus_arb_mux_if.slave bus
);

  logic [SELW-1:0]  enc_idx;
  logic             enc_any;
  logic             enc_multi;
  logic [WIDTH-1:0] win_word;

  logic [WIDTH-1:0] bus_out_q;
  logic             bus_valid_q;
  logic [SELW-1:0]  bus_src_q;
  logic             conflict_q;
  logic             sticky_q;
  logic [CNT_W-1:0] cnt_q;

  bus_prio_enc #(
    .N    (NSRC),
    .SELW (SELW)
  ) u_enc (
    .req   (bus.src_out),
    .index (enc_idx),
    .any   (enc_any),
    .multi (enc_multi)
  );

  // Winner word select; the encoder only ever produces indices below NSRC.
  always_comb begin
    win_word = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (enc_idx == SELW'(i)) win_word = bus.src_data[i*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      bus_out_q   <= '0;
      bus_valid_q <= 1'b0;
      bus_src_q   <= '0;
      conflict_q  <= 1'b0;
    end else begin
      conflict_q <= enc_multi;
      if (enc_any) begin
        bus_out_q   <= win_word;
        bus_src_q   <= enc_idx;
        bus_valid_q <= 1'b1;
      end else begin
        bus_valid_q <= 1'b0;
        if (HOLD_IDLE == 0) bus_out_q <= '0;
      end
    end
  end

  // A clear coinciding with a conflict restarts tracking at that conflict.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      sticky_q <= 1'b0;
      cnt_q    <= '0;
    end else if (bus.conflict_clr) begin
      sticky_q <= enc_multi;
      cnt_q    <= enc_multi ? CNT_W'(1) : '0;
    end else if (enc_multi) begin
      sticky_q <= 1'b1;
      if (!(&cnt_q)) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign bus.bus_out         = bus_out_q;
  assign bus.bus_valid       = bus_valid_q;
  assign bus.bus_src         = bus_src_q;
  assign bus.conflict        = conflict_q;
  assign bus.conflict_sticky = sticky_q;
  assign bus.conflict_cnt    = cnt_q;

endmodule

// File: tb/tb_bus_arb_mux.sv
// Bench for bus_arb_mux: two elaborations (hold/2-bit counter and zero/8-bit counter)
// driven in parallel and compared every cycle against a behavioural bus model.
module tb_bus_arb_mux;
  import bus_pkg::*;

  localparam int W = 32;
  localparam int N = 24;

  logic clk;
  logic clr;

  logic [W-1:0]   words[N];
  logic [N*W-1:0] tb_src_data;
  logic [N-1:0]   tb_src_out;
  logic           tb_cc;

  int n_checks;
  int n_errors;
  bit chk_en;

  bus_arb_mux_if #(.WIDTH(W), .NSRC(N), .CNT_W(2)) ifa ();
  bus_arb_mux_if #(.WIDTH(W), .NSRC(N), .CNT_W(8)) ifb ();

  always_comb begin
    tb_src_data = '0;
    for (int i = 0; i < N; i++) tb_src_data[i*W +: W] = words[i];
  end

  assign ifa.src_data     = tb_src_data;
  assign ifa.src_out      = tb_src_out;
  assign ifa.conflict_clr = tb_cc;
  assign ifb.src_data     = tb_src_data;
  assign ifb.src_out      = tb_src_out;
  assign ifb.conflict_clr = tb_cc;

  bus_arb_mux #(.WIDTH(W), .NSRC(N), .HOLD_IDLE(1), .CNT_W(2)) dut_a (
    .clk (clk),
    .clr (clr),
    .bus (ifa.slave)
  );

  bus_arb_mux #(.WIDTH(W), .NSRC(N), .HOLD_IDLE(0), .CNT_W(8)) dut_b (
    .clk (clk),
    .clr (clr),
    .bus (ifb.slave)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard helper ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model (index 0 = dut_a, 1 = dut_b) ----------------
  int         cnt_max[2] = '{3, 255};
  bit         hold[2]    = '{1'b1, 1'b0};
  logic [W-1:0] m_out[2];
  bit         m_valid[2];
  int         m_src[2];
  bit         m_conf[2];
  bit         m_sticky[2];
  int         m_cnt[2];
  int         nreq;
  int         first;

  always @(posedge clk or negedge clr) begin
    if (!clr) begin
      for (int k = 0; k < 2; k++) begin
        m_out[k] <= '0; m_valid[k] <= 1'b0; m_src[k] <= 0;
        m_conf[k] <= 1'b0; m_sticky[k] <= 1'b0; m_cnt[k] <= 0;
      end
    end else begin
      nreq  = $countones(tb_src_out);
      first = -1;
      for (int i = 0; i < N; i++) if (tb_src_out[i] && first < 0) first = i;
      for (int k = 0; k < 2; k++) begin
        if (nreq > 0) begin
          m_out[k] <= words[first]; m_src[k] <= first; m_valid[k] <= 1'b1;
        end else begin
          m_valid[k] <= 1'b0;
          if (!hold[k]) m_out[k] <= '0;
        end
        m_conf[k] <= (nreq > 1);
        if (tb_cc) begin
          m_sticky[k] <= (nreq > 1);
          m_cnt[k]    <= (nreq > 1) ? 1 : 0;
        end else if (nreq > 1) begin
          m_sticky[k] <= 1'b1;
          m_cnt[k]    <= (m_cnt[k] + 1 > cnt_max[k]) ? cnt_max[k] : m_cnt[k] + 1;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      chk("a_bus_out",   64'(ifa.bus_out),         64'(m_out[0]));
      chk("a_bus_valid", 64'(ifa.bus_valid),       64'(m_valid[0]));
      chk("a_bus_src",   64'(ifa.bus_src),         64'(m_src[0]));
      chk("a_conflict",  64'(ifa.conflict),        64'(m_conf[0]));
      chk("a_sticky",    64'(ifa.conflict_sticky), 64'(m_sticky[0]));
      chk("a_cnt",       64'(ifa.conflict_cnt),    64'(m_cnt[0]));
      chk("b_bus_out",   64'(ifb.bus_out),         64'(m_out[1]));
      chk("b_bus_valid", 64'(ifb.bus_valid),       64'(m_valid[1]));
      chk("b_bus_src",   64'(ifb.bus_src),         64'(m_src[1]));
      chk("b_conflict",  64'(ifb.conflict),        64'(m_conf[1]));
      chk("b_sticky",    64'(ifb.conflict_sticky), 64'(m_sticky[1]));
      chk("b_cnt",       64'(ifb.conflict_cnt),    64'(m_cnt[1]));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input logic [N-1:0] so, input logic cc);
    tb_src_out = so;
    tb_cc      = cc;
    @(posedge clk);
    #1;
  endtask

  task automatic randomize_words();
    for (int i = 0; i < N; i++) words[i] = $urandom;
  endtask

  task automatic random_cycles(input int count);
    logic [N-1:0] so;
    int r;
    for (int c = 0; c < count; c++) begin
      randomize_words();
      r = $urandom_range(0, 9);
      if (r < 2) so = '0;
      else if (r < 7) so = src_bit(bus_src_t'($urandom_range(0, N - 1)));
      else so = N'($urandom) | src_bit(bus_src_t'($urandom_range(0, N - 1)))
                             | src_bit(bus_src_t'($urandom_range(0, N - 1)));
      step(so, ($urandom_range(0, 15) == 0));
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_a_out"},    64'(ifa.bus_out),         64'h0);
    chk({tag, "_a_valid"},  64'(ifa.bus_valid),       64'h0);
    chk({tag, "_a_src"},    64'(ifa.bus_src),         64'h0);
    chk({tag, "_a_conf"},   64'(ifa.conflict),        64'h0);
    chk({tag, "_a_sticky"}, 64'(ifa.conflict_sticky), 64'h0);
    chk({tag, "_a_cnt"},    64'(ifa.conflict_cnt),    64'h0);
    chk({tag, "_b_out"},    64'(ifb.bus_out),         64'h0);
    chk({tag, "_b_valid"},  64'(ifb.bus_valid),       64'h0);
    chk({tag, "_b_cnt"},    64'(ifb.conflict_cnt),    64'h0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    n_checks = 0;
    n_errors = 0;
    chk_en   = 1'b1;
    clr      = 1'b0;
    tb_cc    = 1'b0;
    for (int i = 0; i < N; i++) words[i] = 32'h1000_0000 + i;
    words[0]   = 32'hA5A5_0001;
    tb_src_out = 24'h000001;

    // Reset held with a driver present.
    step(24'h000001, 1'b0);
    step(24'h000001, 1'b0);
    step(24'h000001, 1'b0);
    chk_all_zero("rst");

    // First edge after release produces word0.
    clr = 1'b1;
    step(24'h000001, 1'b0);
    chk("rel_out",   64'(ifa.bus_out),   64'hA5A5_0001);
    chk("rel_valid", 64'(ifa.bus_valid), 64'h1);
    chk("rel_src",   64'(ifa.bus_src),   64'h0);

    // Single driver: MDR.
    words[SRC_MDR] = 32'hDEAD_BEEF;
    step(src_bit(SRC_MDR), 1'b0);
    chk("mdr_out",   64'(ifb.bus_out),   64'hDEAD_BEEF);
    chk("mdr_src",   64'(ifb.bus_src),   64'd21);
    chk("mdr_valid", 64'(ifb.bus_valid), 64'h1);
    chk("mdr_conf",  64'(ifb.conflict),  64'h0);

    // Conflict R3 + PC, then PC alone.
    words[3]      = 32'h0000_0033;
    words[SRC_PC] = 32'h2020_2020;
    step(src_bit(SRC_R3) | src_bit(SRC_PC), 1'b0);
    chk("cf_out",    64'(ifa.bus_out),         64'h33);
    chk("cf_src",    64'(ifa.bus_src),         64'd3);
    chk("cf_conf",   64'(ifa.conflict),        64'h1);
    chk("cf_sticky", 64'(ifa.conflict_sticky), 64'h1);
    chk("cf_cnt",    64'(ifb.conflict_cnt),    64'd1);
    step(src_bit(SRC_PC), 1'b0);
    chk("cf2_conf",   64'(ifa.conflict),        64'h0);
    chk("cf2_sticky", 64'(ifa.conflict_sticky), 64'h1);
    chk("cf2_out",    64'(ifa.bus_out),         64'h2020_2020);

    // Idle: hold vs zero.
    words[5] = 32'h1234_5678;
    step(src_bit(SRC_R5), 1'b0);
    step('0, 1'b0);
    chk("idle_a_out",   64'(ifa.bus_out),   64'h1234_5678);
    chk("idle_b_out",   64'(ifb.bus_out),   64'h0);
    chk("idle_a_valid", 64'(ifa.bus_valid), 64'h0);
    chk("idle_b_src",   64'(ifb.bus_src),   64'd5);

    // Saturation and clear.
    step(src_bit(SRC_R0), 1'b1);
    chk("clr0_cnt",    64'(ifa.conflict_cnt),    64'd0);
    chk("clr0_sticky", 64'(ifa.conflict_sticky), 64'h0);
    for (int i = 0; i < 5; i++) step(24'h000006, 1'b0);
    chk("sat_a_cnt", 64'(ifa.conflict_cnt), 64'd3);
    chk("sat_b_cnt", 64'(ifb.conflict_cnt), 64'd5);
    step(24'h000006, 1'b1);
    chk("clrcf_cnt",    64'(ifa.conflict_cnt),    64'd1);
    chk("clrcf_sticky", 64'(ifa.conflict_sticky), 64'h1);
    step('0, 1'b1);
    chk("clr_cnt",    64'(ifa.conflict_cnt),    64'd0);
    chk("clr_sticky", 64'(ifa.conflict_sticky), 64'h0);

    // Randomized traffic.
    random_cycles(300);

    // Asynchronous reset between edges while the bus is valid.
    randomize_words();
    step(src_bit(SRC_INPORT) | src_bit(SRC_C), 1'b0);
    chk("pre_rst_valid", 64'(ifa.bus_valid), 64'h1);
    #2;
    clr = 1'b0;
    #1;
    chk_all_zero("arst");
    step(src_bit(SRC_HI), 1'b0);
    step(src_bit(SRC_HI), 1'b0);
    clr = 1'b1;
    random_cycles(200);

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
